// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment scanner with shadowed digit data.
// Blink gating is compiled in only when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lzb,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   val_sh_q, val_sh_d;
    logic [DIGITS-1:0]     dpm_sh_q, dpm_sh_d;
    logic [DIGITS-1:0]     en_sh_q, en_sh_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  pcnt_wrap, idx_wrap;
    logic                  blink_hide;
    logic [3:0]            nib;
    logic                  cur_dp, cur_en, lead_zero, lead_blank, visible;
    logic [6:0]            seg_raw;
    logic [DIGITS-1:0]     an_raw;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        pcnt_wrap = (pcnt_q == PW'(SCAN_DIV - 1));
        idx_wrap  = (idx_q == IW'(DIGITS - 1));
        pcnt_d    = pcnt_wrap ? '0 : pcnt_q + PW'(1);
        idx_d     = idx_q;
        if (pcnt_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + IW'(1);
        end
        // load only touches content; the scan position keeps running
        val_sh_d = load ? value    : val_sh_q;
        dpm_sh_d = load ? dp_mask  : dpm_sh_q;
        en_sh_d  = load ? digit_en : en_sh_q;
    end

    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib    = val_sh_q[4*i +: 4];
                cur_dp = dpm_sh_q[i];
                cur_en = en_sh_q[i];
            end
            if (i >= int'(idx_q) && val_sh_q[4*i +: 4] != 4'h0) begin
                lead_zero = 1'b0;
            end
        end
        lead_blank = lzb && (idx_q != '0) && lead_zero;
        visible    = cur_en && !lead_blank && !blink_hide;
        seg_raw    = visible ? hex7(nib) : 7'b0;
        an_raw     = visible ? (DIGITS'(1) << idx_q) : '0;
        seg_d      = seg_raw ^ {7{ACTIVE_LOW}};
        dp_d       = (visible && cur_dp) ^ ACTIVE_LOW;
        an_d       = an_raw ^ {DIGITS{ACTIVE_LOW}};
    end

`ifdef SEG7_SCAN_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_on_q, blink_on_d;

    always_comb begin
        fcnt_d     = fcnt_q;
        blink_on_d = blink_on_q;
        if (pcnt_wrap && idx_wrap) begin
            if (fcnt_q == FW'(BLINK_DIV - 1)) begin
                fcnt_d     = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        blink_hide = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i) && blink_mask[i] && !blink_on_q) begin
                blink_hide = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q     <= '0;
            blink_on_q <= 1'b1;
        end else begin
            fcnt_q     <= fcnt_d;
            blink_on_q <= blink_on_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask ^ (BLINK_DIV == 0);
    assign blink_hide   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q   <= '0;
            idx_q    <= '0;
            val_sh_q <= '0;
            dpm_sh_q <= '0;
            en_sh_q  <= '0;
            seg_q    <= {7{ACTIVE_LOW}};
            dp_q     <= ACTIVE_LOW;
            an_q     <= {DIGITS{ACTIVE_LOW}};
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            val_sh_q <= val_sh_d;
            dpm_sh_q <= dpm_sh_d;
            en_sh_q  <= en_sh_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1, BLINK_DIV=2.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks_n = 0;
    int errors_n = 0;
    int k = 0;

    logic [3:0] an_t  [4];
    logic [6:0] seg_t [4];
    logic       dp_t  [4];

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
        .digit_en(digit_en), .lzb(lzb), .blink_mask(blink_mask),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks_n++;
        assert (an === ea) else begin
            errors_n++;
            $error("FAIL %s an k=%0d got=%b exp=%b", tag, k, an, ea);
        end
        checks_n++;
        assert (seg === es) else begin
            errors_n++;
            $error("FAIL %s seg k=%0d got=%b exp=%b", tag, k, seg, es);
        end
        checks_n++;
        assert (dp === ed) else begin
            errors_n++;
            $error("FAIL %s dp k=%0d got=%b exp=%b", tag, k, dp, ed);
        end
    endtask

    initial begin
        an_t[0] = 4'b1110; seg_t[0] = 7'b1001100; dp_t[0] = 1'b1;
        an_t[1] = 4'b1101; seg_t[1] = 7'b0000110; dp_t[1] = 1'b1;
        an_t[2] = 4'b1011; seg_t[2] = 7'b0010010; dp_t[2] = 1'b0;
        an_t[3] = 4'b0111; seg_t[3] = 7'b1001111; dp_t[3] = 1'b1;

        // reset held 3 cycles
        tick(); tick(); tick();
        chk_out("reset", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_out("idle_no_load", 4'hF, 7'h7F, 1'b1);
        end

        // reset wins over a simultaneous load
        rst = 1'b1; load = 1'b1;
        value = 16'h1234; digit_en = 4'hF; dp_mask = 4'b0100;
        tick();
        chk_out("reset_vs_load", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        k = 0;
        tick();
        chk_out("load_latency", 4'hF, 7'h7F, 1'b1);
        load = 1'b0;

        for (int j = 2; j <= 20; j++) begin
            int d;
            run_to(j);
            d = ((j - 1) / 4) % 4;
            chk_out("scan_1234", an_t[d], seg_t[d], dp_t[d]);
        end

        // mid-digit load of hex letters
        value = 16'hABCD; load = 1'b1;
        tick();
        load = 1'b0;
        chk_out("old_data_digit1", 4'b1101, 7'b0000110, 1'b1);
        tick();
        chk_out("hex_C", 4'b1101, 7'b0110001, 1'b1);
        run_to(25);
        chk_out("hex_b_dp", 4'b1011, 7'b1100000, 1'b0);
        run_to(29);
        chk_out("hex_A", 4'b0111, 7'b0001000, 1'b1);
        run_to(33);
        chk_out("hex_d", 4'b1110, 7'b1000010, 1'b1);

        // leading-zero blanking
        value = 16'h0050; load = 1'b1; lzb = 1'b1;
        tick();
        load = 1'b0;
        run_to(35);
        chk_out("lzb_digit0", 4'b1110, 7'b0000001, 1'b1);
        run_to(37);
        chk_out("lzb_digit1_5", 4'b1101, 7'b0100100, 1'b1);
        run_to(41);
        chk_out("lzb_digit2_blank", 4'hF, 7'h7F, 1'b1);
        run_to(45);
        chk_out("lzb_digit3_blank", 4'hF, 7'h7F, 1'b1);
        run_to(48);
        value = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0;
        run_to(50);
        chk_out("lzb_zero_digit0", 4'b1110, 7'b0000001, 1'b1);
        run_to(53);
        chk_out("lzb_zero_digit1", 4'hF, 7'h7F, 1'b1);
        run_to(66);
        lzb = 1'b0;
        run_to(69);
        chk_out("lzb_off_digit1", 4'b1101, 7'b0000001, 1'b1);

        // reset in the middle of digit 2
        run_to(74);
        chk_out("pre_reset_digit2", 4'b1011, 7'b0000001, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("reset_midscan", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0; load = 1'b1; value = 16'h1234; blink_mask = 4'b0001;
        k = 0;
        tick();
        load = 1'b0;
        chk_out("reload_latency", 4'hF, 7'h7F, 1'b1);
        run_to(2);
        chk_out("restart_digit0", an_t[0], seg_t[0], dp_t[0]);
        run_to(5);
        chk_out("restart_digit1", an_t[1], seg_t[1], dp_t[1]);

        // blink frames: phase flips at the end of frames 1 and 3
        run_to(18);
        chk_out("blink_frame1_d0", an_t[0], seg_t[0], dp_t[0]);
        run_to(34);
`ifdef SEG7_SCAN_BLINK_EN
        chk_out("blink_frame2_d0", 4'hF, 7'h7F, 1'b1);
`else
        chk_out("steady_frame2_d0", an_t[0], seg_t[0], dp_t[0]);
`endif
        run_to(38);
        chk_out("blink_frame2_d1", an_t[1], seg_t[1], dp_t[1]);
        run_to(50);
`ifdef SEG7_SCAN_BLINK_EN
        chk_out("blink_frame3_d0", 4'hF, 7'h7F, 1'b1);
`else
        chk_out("steady_frame3_d0", an_t[0], seg_t[0], dp_t[0]);
`endif
        run_to(58);
        chk_out("blink_frame3_d2", an_t[2], seg_t[2], dp_t[2]);
        run_to(66);
        chk_out("blink_frame4_d0", an_t[0], seg_t[0], dp_t[0]);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule
